// File: rtl/unidade_controle_pc.sv
// PC control unit: fetch/decode/execute FSM that sequences the PC, IR and
// register-file write strobes and selects the next-PC value.
module unidade_controle_pc (
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] SaidaPC,
    input  logic [3:0] Opcode,
    input  logic       Zero,
    input  logic [7:0] Desvio,
    input  logic       MemPronta,
    output logic [7:0] EntradaPC,
    output logic       EscPC,
    output logic       EscIR,
    output logic       LerMem,
    output logic       EscReg,
    output logic       Halt,
    output logic [1:0] Estado,
    output logic [7:0] ContInstr
);

    localparam logic [1:0] BUSCA  = 2'd0;
    localparam logic [1:0] DECOD  = 2'd1;
    localparam logic [1:0] EXEC   = 2'd2;
    localparam logic [1:0] PARADO = 2'd3;

    localparam logic [3:0] OP_NOP = 4'h0;
    localparam logic [3:0] OP_ALU = 4'h1;
    localparam logic [3:0] OP_BEQ = 4'h2;
    localparam logic [3:0] OP_BNE = 4'h3;
    localparam logic [3:0] OP_JMP = 4'h4;
    localparam logic [3:0] OP_HLT = 4'hF;

    logic [1:0] state_r;
    logic [1:0] next_state_s;
    logic [3:0] opcode_r;
    logic [7:0] cont_instr_r;
    logic [7:0] entrada_pc_s;
    logic       esc_pc_s;
    logic       esc_ir_s;
    logic       ler_mem_s;
    logic       esc_reg_s;
    logic       halt_s;

    // 8-bit modulo increment; carry out is deliberately discarded
    function automatic logic [7:0] pc_inc(input logic [7:0] pc);
        return pc + 8'd1;
    endfunction

    // Next-state, strobe and next-PC decode; reset masks every strobe
    always_comb begin
        next_state_s = state_r;
        entrada_pc_s = pc_inc(SaidaPC);
        esc_pc_s     = 1'b0;
        esc_ir_s     = 1'b0;
        ler_mem_s    = 1'b0;
        esc_reg_s    = 1'b0;
        halt_s       = 1'b0;
        case (state_r)
            BUSCA: begin
                ler_mem_s = 1'b1;
                if (MemPronta) begin
                    esc_ir_s     = 1'b1;
                    next_state_s = DECOD;
                end else begin
                    next_state_s = BUSCA;
                end
            end
            DECOD: begin
                next_state_s = EXEC;
            end
            EXEC: begin
                esc_pc_s     = 1'b1;
                next_state_s = BUSCA;
                case (opcode_r)
                    OP_NOP: entrada_pc_s = pc_inc(SaidaPC);
                    OP_ALU: esc_reg_s = 1'b1;
                    OP_BEQ: begin
                        if (Zero) begin
                            entrada_pc_s = Desvio;
                        end else begin
                            entrada_pc_s = pc_inc(SaidaPC);
                        end
                    end
                    OP_BNE: begin
                        if (!Zero) begin
                            entrada_pc_s = Desvio;
                        end else begin
                            entrada_pc_s = pc_inc(SaidaPC);
                        end
                    end
                    OP_JMP: entrada_pc_s = Desvio;
                    OP_HLT: begin
                        esc_pc_s     = 1'b0;
                        next_state_s = PARADO;
                    end
                    default: entrada_pc_s = pc_inc(SaidaPC);
                endcase
            end
            PARADO: begin
                halt_s       = 1'b1;
                next_state_s = PARADO;
            end
            default: begin
                next_state_s = BUSCA;
            end
        endcase
        if (!reset) begin
            esc_pc_s  = 1'b0;
            esc_ir_s  = 1'b0;
            ler_mem_s = 1'b0;
            esc_reg_s = 1'b0;
            halt_s    = 1'b0;
        end else begin
            halt_s = halt_s;
        end
    end

    // State, latched opcode and saturating executed-instruction counter
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_r      <= BUSCA;
            opcode_r     <= OP_NOP;
            cont_instr_r <= 8'h00;
        end else begin
            state_r <= next_state_s;
            if (state_r == DECOD) begin
                opcode_r <= Opcode;
            end
            if (state_r == EXEC && cont_instr_r != 8'hFF) begin
                cont_instr_r <= cont_instr_r + 8'd1;
            end
        end
    end

    assign EntradaPC = entrada_pc_s;
    assign EscPC     = esc_pc_s;
    assign EscIR     = esc_ir_s;
    assign LerMem    = ler_mem_s;
    assign EscReg    = esc_reg_s;
    assign Halt      = halt_s;
    assign Estado    = state_r;
    assign ContInstr = cont_instr_r;

endmodule

// File: tb/tb_unidade_controle_pc.sv
// Directed bench for unidade_controle_pc: expected output vectors are queued
// as each cycle is driven and compared at the following falling edge.
module tb_unidade_controle_pc;

    logic       clock;
    logic       reset;
    logic [7:0] SaidaPC;
    logic [3:0] Opcode;
    logic       Zero;
    logic [7:0] Desvio;
    logic       MemPronta;
    logic [7:0] EntradaPC;
    logic       EscPC;
    logic       EscIR;
    logic       LerMem;
    logic       EscReg;
    logic       Halt;
    logic [1:0] Estado;
    logic [7:0] ContInstr;

    // strobe vector order: EscPC, EscIR, LerMem, EscReg, Halt
    localparam logic [4:0] S_NONE = 5'b00000;
    localparam logic [4:0] S_PC   = 5'b10000;
    localparam logic [4:0] S_IR   = 5'b01000;
    localparam logic [4:0] S_LER  = 5'b00100;
    localparam logic [4:0] S_REG  = 5'b00010;
    localparam logic [4:0] S_HALT = 5'b00001;

    typedef struct {
        string       tag;
        logic [22:0] v;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    unidade_controle_pc dut (
        .clock     (clock),
        .reset     (reset),
        .SaidaPC   (SaidaPC),
        .Opcode    (Opcode),
        .Zero      (Zero),
        .Desvio    (Desvio),
        .MemPronta (MemPronta),
        .EntradaPC (EntradaPC),
        .EscPC     (EscPC),
        .EscIR     (EscIR),
        .LerMem    (LerMem),
        .EscReg    (EscReg),
        .Halt      (Halt),
        .Estado    (Estado),
        .ContInstr (ContInstr)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic step(input string tag, input logic [1:0] est, input logic [4:0] strb,
                        input logic [7:0] ent, input logic [7:0] cnt);
        exp_t        e;
        logic [22:0] obs;
        e.tag = tag;
        e.v   = {est, strb, ent, cnt};
        sb.push_back(e);
        @(negedge clock);
        e   = sb.pop_front();
        obs = {Estado, EscPC, EscIR, LerMem, EscReg, Halt, EntradaPC, ContInstr};
        checks++;
        assert (obs === e.v) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h (est,strb[5],EntradaPC,ContInstr)",
                   e.tag, obs, e.v);
        end
        @(posedge clock);
        #1;
    endtask

    // one full instruction with MemPronta already high
    task automatic instr(input string tag, input logic [7:0] pc, input logic [3:0] op,
                         input logic z, input logic [7:0] dv, input logic [4:0] ex_strb,
                         input logic [7:0] ex_ent, input logic [7:0] cnt);
        logic [7:0] pc1;
        pc1       = pc + 8'd1;
        SaidaPC   = pc;
        Opcode    = op;
        Desvio    = dv;
        MemPronta = 1'b1;
        Zero      = ~z;
        step({tag, "_busca"}, 2'd0, S_IR | S_LER, pc1, cnt);
        step({tag, "_decod"}, 2'd1, S_NONE, pc1, cnt);
        Zero   = z;
        Opcode = 4'h0;
        step({tag, "_exec"}, 2'd2, ex_strb, ex_ent, cnt);
    endtask

    initial begin
        reset     = 1'b0;
        SaidaPC   = 8'h10;
        Opcode    = 4'h1;
        Zero      = 1'b0;
        Desvio    = 8'h00;
        MemPronta = 1'b1;
        @(posedge clock);
        #1;
        step("reset_hold", 2'd0, S_NONE, 8'h11, 8'h00);
        reset = 1'b1;

        instr("alu",     8'h10, 4'h1, 1'b0, 8'h00, S_PC | S_REG, 8'h11, 8'h00);
        instr("beq_t",   8'h11, 4'h2, 1'b1, 8'h40, S_PC, 8'h40, 8'h01);
        instr("beq_nt",  8'h20, 4'h2, 1'b0, 8'h40, S_PC, 8'h21, 8'h02);
        instr("bne_t",   8'h30, 4'h3, 1'b0, 8'h55, S_PC, 8'h55, 8'h03);
        instr("bne_nt",  8'h30, 4'h3, 1'b1, 8'h55, S_PC, 8'h31, 8'h04);
        instr("nop_wrap", 8'hFF, 4'h0, 1'b0, 8'h12, S_PC, 8'h00, 8'h05);
        instr("unk_op",  8'h05, 4'h7, 1'b1, 8'h99, S_PC, 8'h06, 8'h06);

        // fetch stall, then JMP
        SaidaPC   = 8'h06;
        Opcode    = 4'h4;
        Desvio    = 8'h77;
        MemPronta = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step("stall_busca", 2'd0, S_LER, 8'h07, 8'h07);
        end
        MemPronta = 1'b1;
        step("stall_ready", 2'd0, S_IR | S_LER, 8'h07, 8'h07);
        step("jmp_decod", 2'd1, S_NONE, 8'h07, 8'h07);
        step("jmp_exec", 2'd2, S_PC, 8'h77, 8'h07);

        // reset in the middle of a JMP execute
        step("jmp2_busca", 2'd0, S_IR | S_LER, 8'h07, 8'h08);
        step("jmp2_decod", 2'd1, S_NONE, 8'h07, 8'h08);
        reset = 1'b0;
        step("jmp2_exec_rst", 2'd2, S_NONE, 8'h77, 8'h08);
        reset = 1'b1;
        step("after_rst_busca", 2'd0, S_IR | S_LER, 8'h07, 8'h00);

        // HLT then absorbing PARADO
        Opcode = 4'hF;
        step("hlt_decod", 2'd1, S_NONE, 8'h07, 8'h00);
        step("hlt_exec", 2'd2, S_NONE, 8'h07, 8'h00);
        for (int i = 0; i < 10; i++) begin
            Zero   = i[0];
            Opcode = 4'h4;
            step("parado", 2'd3, S_HALT, 8'h07, 8'h01);
        end
        reset = 1'b0;
        step("parado_rst", 2'd3, S_NONE, 8'h07, 8'h01);
        reset = 1'b1;
        step("post_halt_busca", 2'd0, S_IR | S_LER, 8'h07, 8'h00);
        step("post_halt_decod", 2'd1, S_NONE, 8'h07, 8'h00);
        step("post_halt_exec", 2'd2, S_PC, 8'h77, 8'h00);

        // counter saturation at 0xFF
        for (int k = 1; k < 262; k++) begin
            logic [7:0] cexp;
            logic [7:0] pc;
            logic [7:0] pc1;
            cexp = (k > 255) ? 8'hFF : 8'(k);
            pc   = 8'(k * 3);
            pc1  = pc + 8'd1;
            instr("sat", pc, 4'h0, 1'b0, 8'h00, S_PC, pc1, cexp);
        end
        SaidaPC = 8'h40;
        step("sat_final", 2'd0, S_IR | S_LER, 8'h41, 8'hFF);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/unidade_controle_pc.md
UNIDADE_CONTROLE_PC -- requirements
Module: unidade_controle_pc

Interface
REQ-001 The block SHALL have exactly one clock and one reset: reset is synchronous and active-low.
REQ-002 Port `clock`  input  1  the only clock; all state changes on its rising edge.
REQ-003 Port `reset`  input  1  synchronous, active-low reset; sampled only at the rising edge of `clock`.
REQ-004 Port `SaidaPC`  input  8  current PC value, from the PC register.
REQ-005 Port `Opcode`  input  4  opcode field of the instruction register.
REQ-006 Port `Zero`  input  1  ALU zero flag.
REQ-007 Port `Desvio`  input  8  branch/jump target address.
REQ-008 Port `MemPronta`  input  1  instruction memory ready, valid while `LerMem`=1.
REQ-009 Port `EntradaPC`  output  8  next-PC value driven to the PC register.
REQ-010 Port `EscPC`  output  1  PC write enable.
REQ-011 Port `EscIR`  output  1  instruction register write enable.
REQ-012 Port `LerMem`  output  1  instruction memory read request.
REQ-013 Port `EscReg`  output  1  register file write enable.
REQ-014 Port `Halt`  output  1  processor halted.
REQ-015 Port `Estado`  output  2  current FSM state encoding.
REQ-016 Port `ContInstr`  output  8  count of executed instructions.

Function
REQ-017 The FSM SHALL have four states: BUSCA=0, DECOD=1, EXEC=2 and PARADO=3, and `Estado` SHALL equal the current state.
REQ-018 In BUSCA: `LerMem`=1; if `MemPronta`=0, stay in BUSCA (wait indefinitely, other strobes 0); if `MemPronta`=1, `EscIR`=1 in that same cycle and next state is DECOD.
REQ-019 In DECOD: all strobes are 0; `Opcode` is latched into an internal register at the end of the cycle; next state is EXEC.
REQ-020 In EXEC: the action depends on the latched opcode.
  - 0x0 NOP: PC+1.
  - 0x1 ALU: PC+1 with `EscReg`=1.
  - 0x2 BEQ: `Desvio` if `Zero`=1, else PC+1.
  - 0x3 BNE: `Desvio` if `Zero`=0, else PC+1.
  - 0x4 JMP: `Desvio`.
  - 0xF HLT: `EscPC`=0 and next state PARADO.
  - Any other opcode: treated as NOP.
REQ-021 In EXEC for every opcode other than HLT: `EscPC`=1 for exactly that one cycle, and next state is BUSCA.
REQ-022 `EntradaPC` SHALL be combinational from state, latched opcode, `Zero`, `Desvio` and `SaidaPC`; outside EXEC it SHALL equal `SaidaPC`+1.
REQ-023 PC+1 SHALL be 8-bit modulo: 0xFF+1 = 0x00, with no carry output.
REQ-024 `Zero` SHALL be sampled only during EXEC; its value in other states has no effect.
REQ-025 PARADO SHALL be absorbing until reset, with `Halt`=1 and all strobes 0.
REQ-026 `ContInstr` SHALL increment by 1 at the end of every EXEC cycle, HLT included, and saturate at 0xFF.
REQ-027 `EscPC`, `EscIR` and `EscReg` SHALL never be 1 outside the states stated above.
REQ-028 Minimum instruction latency SHALL be 3 cycles (BUSCA with `MemPronta`=1, DECOD, EXEC).

Reset
REQ-029 When `reset`=0 at a rising edge, the next state SHALL be BUSCA, `ContInstr` SHALL be 0x00 and the latched opcode SHALL be 0x0.
REQ-030 While `reset`=0, `EscPC`, `EscIR`, `EscReg`, `LerMem` and `Halt` SHALL be forced to 0 combinationally.
REQ-031 Reset asserted in any state, including mid-EXEC or PARADO, SHALL abort the current instruction with no PC write in that cycle.
REQ-032 On the first cycle after reset deassertion, the block SHALL be in BUSCA with `LerMem`=1.

Verification
REQ-033 ALU at PC=0x10, `MemPronta`=1 immediately -> `Estado` 0,1,2; `EscReg`=1 and `EscPC`=1 in cycle 3 only; `EntradaPC`=0x11; `ContInstr`=1.
REQ-034 BEQ, `Desvio`=0x40, `Zero`=1 -> `EntradaPC`=0x40 with `EscPC`=1; same with `Zero`=0 at PC=0x20 -> `EntradaPC`=0x21.
REQ-035 NOP at PC=0xFF -> `EntradaPC`=0x00 in EXEC.
REQ-036 `MemPronta` held 0 for 5 cycles -> state stays BUSCA, `LerMem`=1, `EscIR`=0; on `MemPronta`=1, `EscIR`=1 for one cycle, then DECOD.
REQ-037 HLT -> `Estado`=3, `Halt`=1, `EscPC`=0 thereafter for 10 or more cycles; then `reset`=0 for 1 cycle -> `Estado`=0, `Halt`=0, `ContInstr`=0.
REQ-038 `reset`=0 during EXEC of a JMP -> no `EscPC` pulse, next state BUSCA.
